regfile_writeback_arbiter: RTL

- Write-side companion of the dual-write-port register file.
- Each cycle it merges three result sources: two in-order pipe results (pipe 1 older, pipe 2 younger) and one long-latency result stream (mul/div/load miss) with a valid/ready handshake.
- Outputs drive the register file's Write_Enable/Addr/Data port pairs, registered.
- Long-latency results that find no free write port wait in a small ordered buffer. Issue logic reads a per-register pending mask from this block to stall dependent reads.

---
 rtl/regfile_writeback_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/regfile_writeback_arbiter.sv
// Write-back arbiter: merges two in-order pipe results and an ordered long-latency
// result buffer onto the register file's two registered write ports.
module regfile_writeback_arbiter #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   p1_valid,
   input  logic [ADDR_W-1:0]      p1_addr,
   input  logic [DATA_W-1:0]      p1_data,
   input  logic                   p2_valid,
   input  logic [ADDR_W-1:0]      p2_addr,
   input  logic [DATA_W-1:0]      p2_data,
   input  logic                   lr_valid,
   output logic                   lr_ready,
   input  logic [ADDR_W-1:0]      lr_addr,
   input  logic [DATA_W-1:0]      lr_data,
   output logic                   Write_Enable_1,
   output logic [ADDR_W-1:0]      Write_Addr_1,
   output logic [DATA_W-1:0]      Write_Data_1,
   output logic                   Write_Enable_2,
   output logic [ADDR_W-1:0]      Write_Addr_2,
   output logic [DATA_W-1:0]      Write_Data_2,
   output logic [2**ADDR_W-1:0]   pending_mask,
   output logic [$clog2(DEPTH):0] fifo_count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DEPTH-1:0]             live_q, live_n;
   logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_n;
   logic [DEPTH-1:0][DATA_W-1:0] data_q, data_n;
   logic [PTR_W-1:0]             head_q, head_n, idx, tail;
   logic [CNT_W-1:0]             count_n, pops;
   logic                         e1, e2, in_live, free1, free2, stop, push, empty_after;
   logic                         we1_n, we2_n;
   logic [ADDR_W-1:0]            wa1_n, wa2_n;
   logic [DATA_W-1:0]            wd1_n, wd2_n;
   logic [2**ADDR_W-1:0]         mask_n;

   assign e2       = p2_valid && (p2_addr != '0);
   assign e1       = p1_valid && (p1_addr != '0) && !(e2 && (p2_addr == p1_addr));
   assign lr_ready = (fifo_count != CNT_W'(DEPTH));
   // An incoming result overwritten by a same-cycle pipe write is simply dropped.
   assign in_live  = lr_valid && lr_ready && (lr_addr != '0) &&
                     !(e1 && (lr_addr == p1_addr)) && !(e2 && (lr_addr == p2_addr));

   always_comb begin
      live_n = live_q;
      addr_n = addr_q;
      data_n = data_q;
      pops   = '0;
      stop   = 1'b0;
      push   = 1'b0;
      idx    = head_q;
      tail   = head_q + fifo_count[PTR_W-1:0];
      free1  = !e1;
      free2  = !e2;
      we1_n  = e1;
      wa1_n  = e1 ? p1_addr : Write_Addr_1;
      wd1_n  = e1 ? p1_data : Write_Data_1;
      we2_n  = e2;
      wa2_n  = e2 ? p2_addr : Write_Addr_2;
      wd2_n  = e2 ? p2_data : Write_Data_2;

      // The live incoming result also kills older entries, so a drained entry and
      // a bypassed result can never target the same register in one cycle.
      for (int i = 0; i < DEPTH; i++)
         if (live_q[i] && ((e1 && addr_q[i] == p1_addr) || (e2 && addr_q[i] == p2_addr) ||
                           (in_live && addr_q[i] == lr_addr)))
            live_n[i] = 1'b0;

      for (int k = 0; k < 2; k++) begin
         idx = head_q + PTR_W'(k);
         if (!stop && (CNT_W'(k) < fifo_count)) begin
            if (live_n[idx]) begin
               if (free1) begin
                  we1_n = 1'b1; wa1_n = addr_q[idx]; wd1_n = data_q[idx]; free1 = 1'b0;
               end else if (free2) begin
                  we2_n = 1'b1; wa2_n = addr_q[idx]; wd2_n = data_q[idx]; free2 = 1'b0;
               end else
                  stop = 1'b1;
            end
            if (!stop) begin
               live_n[idx] = 1'b0;
               pops        = pops + 1'b1;
            end
         end
      end

      empty_after = (pops == fifo_count);
      if (in_live) begin
         if (empty_after && free1) begin
            we1_n = 1'b1; wa1_n = lr_addr; wd1_n = lr_data;
         end else if (empty_after && free2) begin
            we2_n = 1'b1; wa2_n = lr_addr; wd2_n = lr_data;
         end else begin
            push         = 1'b1;
            live_n[tail] = 1'b1;
            addr_n[tail] = lr_addr;
            data_n[tail] = lr_data;
         end
      end

      head_n  = head_q + pops[PTR_W-1:0];
      count_n = fifo_count - pops + CNT_W'(push);
      mask_n  = '0;
      for (int i = 0; i < DEPTH; i++)
         if (live_n[i]) mask_n[addr_n[i]] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         live_q         <= '0;
         addr_q         <= '0;
         data_q         <= '0;
         head_q         <= '0;
         fifo_count     <= '0;
         pending_mask   <= '0;
         Write_Enable_1 <= 1'b0;
         Write_Addr_1   <= '0;
         Write_Data_1   <= '0;
         Write_Enable_2 <= 1'b0;
         Write_Addr_2   <= '0;
         Write_Data_2   <= '0;
      end else begin
         live_q         <= live_n;
         addr_q         <= addr_n;
         data_q         <= data_n;
         head_q         <= head_n;
         fifo_count     <= count_n;
         pending_mask   <= mask_n;
         Write_Enable_1 <= we1_n;
         Write_Addr_1   <= wa1_n;
         Write_Data_1   <= wd1_n;
         Write_Enable_2 <= we2_n;
         Write_Addr_2   <= wa2_n;
         Write_Data_2   <= wd2_n;
      end
   end
endmodule
